hash_job_arbiter: RTL and testbench

HASH_JOB_ARBITER -- requirements
Module: hash_job_arbiter

---
 rtl/hash_job_arbiter.sv | 159 +++++++++++++++
 tb/tb_hash_job_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_job_arbiter.sv
// Round-robin arbiter that hands hash jobs from NREQ requesters to a single hash core,
// waits for completion or timeout, and returns a one-cycle response to the job owner.
module hash_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_opcode,
  input  logic [32*NREQ-1:0]   req_message_addr,
  input  logic [32*NREQ-1:0]   req_size,
  input  logic [32*NREQ-1:0]   req_output_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic                 resp_err,
  output logic                 core_start,
  output logic [1:0]           core_opcode,
  output logic [31:0]          core_message_addr,
  output logic [31:0]          core_size,
  output logic [31:0]          core_output_addr,
  input  logic                 core_done,
  output logic                 busy,
  output logic [2:0]           owner
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = PW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   owner_reg;
  logic [CW-1:0]   count_reg;
  logic            done_q_reg;
  logic            err_reg;
  logic [1:0]      opcode_reg;
  logic [31:0]     message_addr_reg;
  logic [31:0]     size_reg;
  logic [31:0]     output_addr_reg;

  logic [1:0]      op_arr   [NREQ];
  logic [31:0]     msg_arr  [NREQ];
  logic [31:0]     size_arr [NREQ];
  logic [31:0]     out_arr  [NREQ];

  logic            grant_found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   rr_ptr_next;
  logic [IW-1:0]   idx;
  logic            grant_en;
  logic            resp_en;
  logic            done_rise;
  logic            timed_out;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi]   = req_opcode[2*gi +: 2];
      assign msg_arr[gi]  = req_message_addr[32*gi +: 32];
      assign size_arr[gi] = req_size[32*gi +: 32];
      assign out_arr[gi]  = req_output_addr[32*gi +: 32];
      assign req_ready[gi]  = grant_en && (winner == PW'(gi));
      assign resp_valid[gi] = resp_en && (owner_reg == PW'(gi));
    end
  endgenerate

  // Search starts at rr_ptr and wraps, so the first valid requester at or after it wins.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_reg} + IW'(k);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!grant_found && req_valid[idx[PW-1:0]]) begin
        grant_found = 1'b1;
        winner      = idx[PW-1:0];
      end
    end
    rr_ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
  end

  // A done level already high before BUSY is not a completion; only a fresh rise counts.
  assign done_rise = core_done && !done_q_reg;
  assign timed_out = (count_reg == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      owner_reg        <= '0;
      count_reg        <= '0;
      done_q_reg       <= 1'b0;
      err_reg          <= 1'b0;
      opcode_reg       <= '0;
      message_addr_reg <= '0;
      size_reg         <= '0;
      output_addr_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      done_q_reg <= core_done;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            owner_reg        <= winner;
            rr_ptr_reg       <= rr_ptr_next;
            opcode_reg       <= op_arr[winner];
            message_addr_reg <= msg_arr[winner];
            size_reg         <= size_arr[winner];
            output_addr_reg  <= out_arr[winner];
          end
        end
        ISSUE: count_reg <= '0;
        BUSY: begin
          if (!timed_out) count_reg <= count_reg + CW'(1);
          if (done_rise) err_reg <= 1'b0;
          else if (timed_out) err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = BUSY;
      BUSY:    if (done_rise || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are gated by reset so they are inactive for the whole time reset is held.
  always_comb begin
    grant_en   = 1'b0;
    resp_en    = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      grant_en   = (state_reg == IDLE) && grant_found;
      core_start = (state_reg == ISSUE);
      resp_en    = (state_reg == RESP);
      busy       = (state_reg != IDLE);
    end
  end

  assign resp_err          = resp_en && err_reg;
  assign core_opcode       = opcode_reg;
  assign core_message_addr = message_addr_reg;
  assign core_size         = size_reg;
  assign core_output_addr  = output_addr_reg;
  assign owner             = 3'(owner_reg);

endmodule

// File: tb/tb_hash_job_arbiter.sv
// Directed bench for hash_job_arbiter: instance a uses the default timeout,
// instance b uses TIMEOUT=16 for the timeout scenarios. Both share the stimulus.
module tb_hash_job_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [7:0]   req_opcode;
  logic [127:0] req_message_addr, req_size, req_output_addr;
  logic         core_done;

  logic [3:0]  req_ready_a, resp_valid_a, req_ready_b, resp_valid_b;
  logic        resp_err_a, core_start_a, busy_a, resp_err_b, core_start_b, busy_b;
  logic [1:0]  core_opcode_a, core_opcode_b;
  logic [31:0] core_message_addr_a, core_size_a, core_output_addr_a;
  logic [31:0] core_message_addr_b, core_size_b, core_output_addr_b;
  logic [2:0]  owner_a, owner_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hash_job_arbiter #(.NREQ(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_message_addr(req_message_addr), .req_size(req_size), .req_output_addr(req_output_addr),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_err(resp_err_a),
    .core_start(core_start_a), .core_opcode(core_opcode_a),
    .core_message_addr(core_message_addr_a), .core_size(core_size_a),
    .core_output_addr(core_output_addr_a), .core_done(core_done), .busy(busy_a), .owner(owner_a)
  );

  hash_job_arbiter #(.NREQ(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_message_addr(req_message_addr), .req_size(req_size), .req_output_addr(req_output_addr),
    .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_err(resp_err_b),
    .core_start(core_start_b), .core_opcode(core_opcode_b),
    .core_message_addr(core_message_addr_b), .core_size(core_size_b),
    .core_output_addr(core_output_addr_b), .core_done(core_done), .busy(busy_b), .owner(owner_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [1:0] op, input logic [31:0] m,
                            input logic [31:0] s, input logic [31:0] o);
    req_opcode[2*i +: 2]         = op;
    req_message_addr[32*i +: 32] = m;
    req_size[32*i +: 32]         = s;
    req_output_addr[32*i +: 32]  = o;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; core_done = 1'b0;
    req_opcode = '0; req_message_addr = '0; req_size = '0; req_output_addr = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111; core_done = 1'b0;
    for (int i = 0; i < 4; i++) set_fields(i, 2'b11, 32'hAAAA_0000, 32'h55, 32'hBBBB_0000);
    cyc(); cyc();
    #1;
    n_vec++; if (req_ready_a !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b want=0000", req_ready_a); end
    n_vec++; if (busy_a !== 1'b0 || core_start_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_start got=%b%b want=00", busy_a, core_start_a); end
    n_vec++; if (resp_valid_a !== 4'b0000 || resp_err_a !== 1'b0) begin n_err++; $display("FAIL reset_resp got=%b/%b want=0000/0", resp_valid_a, resp_err_a); end
    n_vec++; if (owner_a !== 3'd0 || core_size_a !== 32'd0 || core_opcode_a !== 2'd0 || core_message_addr_a !== 32'd0 || core_output_addr_a !== 32'd0)
      begin n_err++; $display("FAIL reset_fields got owner=%0d size=%h op=%b want 0", owner_a, core_size_a, core_opcode_a); end
    $display("reset checked");
  endtask

  task automatic test_single_job();
    apply_reset();
    set_fields(0, 2'b01, 32'h0000_1000, 32'h14, 32'h0000_2000);
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready_a !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b want=0001", req_ready_a); end
    cyc();
    req_valid = 4'b0000;
    #1;
    n_vec++; if (core_start_a !== 1'b1 || busy_a !== 1'b1) begin n_err++; $display("FAIL single_start got start=%b busy=%b want 1 1", core_start_a, busy_a); end
    n_vec++; if (core_opcode_a !== 2'b01 || core_size_a !== 32'h14 || core_message_addr_a !== 32'h1000 || core_output_addr_a !== 32'h2000)
      begin n_err++; $display("FAIL single_fields got op=%b size=%h msg=%h out=%h want 01 14 1000 2000", core_opcode_a, core_size_a, core_message_addr_a, core_output_addr_a); end
    repeat (50) cyc();
    n_vec++; if (resp_valid_a !== 4'b0000 || core_start_a !== 1'b0) begin n_err++; $display("FAIL single_early_resp got resp=%b start=%b want 0000 0", resp_valid_a, core_start_a); end
    core_done = 1'b1;
    cyc();
    n_vec++; if (resp_valid_a !== 4'b0001 || resp_err_a !== 1'b0) begin n_err++; $display("FAIL single_resp got=%b err=%b want=0001 err=0", resp_valid_a, resp_err_a); end
    core_done = 1'b0;
    cyc();
    n_vec++; if (resp_valid_a !== 4'b0000 || busy_a !== 1'b0) begin n_err++; $display("FAIL single_idle got resp=%b busy=%b want 0000 0", resp_valid_a, busy_a); end
    $display("single job: requester 0 size 0x14 done");
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    apply_reset();
    for (int i = 0; i < 4; i++) set_fields(i, 2'(i), 32'h100 * (i + 1), 32'(i + 1), 32'h9000 + 32'(i));
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      exp_oh = 4'b0001 << order[j];
      n_vec++; if (req_ready_a !== exp_oh) begin n_err++; $display("FAIL contention_grant%0d got=%b want=%b", j, req_ready_a, exp_oh); end
      cyc();
      n_vec++; if (owner_a !== 3'(order[j]) || core_size_a !== 32'(order[j] + 1))
        begin n_err++; $display("FAIL contention_owner%0d got owner=%0d size=%0d want %0d %0d", j, owner_a, core_size_a, order[j], order[j] + 1); end
      cyc();
      core_done = 1'b1;
      cyc();
      n_vec++; if (resp_valid_a !== exp_oh) begin n_err++; $display("FAIL contention_resp%0d got=%b want=%b", j, resp_valid_a, exp_oh); end
      core_done = 1'b0;
      cyc();
      $display("contention job %0d: owner %0d", j, order[j]);
    end
  endtask

  task automatic test_stale_done();
    apply_reset();
    core_done = 1'b1;
    set_fields(1, 2'b10, 32'h3000, 32'h40, 32'h4000);
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready_a !== 4'b0010) begin n_err++; $display("FAIL stale_ready got=%b want=0010", req_ready_a); end
    cyc();
    req_valid = 4'b0000;
    cyc(); cyc(); cyc(); cyc();
    n_vec++; if (resp_valid_a !== 4'b0000 || busy_a !== 1'b1) begin n_err++; $display("FAIL stale_no_complete got resp=%b busy=%b want 0000 1", resp_valid_a, busy_a); end
    core_done = 1'b0;
    cyc();
    n_vec++; if (busy_a !== 1'b1 || resp_valid_a !== 4'b0000) begin n_err++; $display("FAIL stale_fall got busy=%b resp=%b want 1 0000", busy_a, resp_valid_a); end
    core_done = 1'b1;
    cyc();
    n_vec++; if (resp_valid_a !== 4'b0010 || resp_err_a !== 1'b0) begin n_err++; $display("FAIL stale_resp got=%b err=%b want=0010 err=0", resp_valid_a, resp_err_a); end
    core_done = 1'b0;
    cyc();
    $display("stale done: requester 1 completed on fresh rise");
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    set_fields(2, 2'b00, 32'h5000, 32'h8, 32'h6000);
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0000;
    cyc();
    // First BUSY cycle holds counter 0; RESP follows the cycle where the counter reads 16.
    n = 0;
    while (resp_valid_b === 4'b0000 && n < 40) begin
      cyc();
      n++;
    end
    n_vec++; if (n !== 17) begin n_err++; $display("FAIL timeout_cycles got=%0d want=17", n); end
    n_vec++; if (resp_valid_b !== 4'b0100 || resp_err_b !== 1'b1) begin n_err++; $display("FAIL timeout_resp got=%b err=%b want=0100 err=1", resp_valid_b, resp_err_b); end
    cyc();
    n_vec++; if (busy_b !== 1'b0 || resp_valid_b !== 4'b0000) begin n_err++; $display("FAIL timeout_idle got busy=%b resp=%b want 0 0000", busy_b, resp_valid_b); end
    $display("timeout: requester 2 err response after %0d cycles", n);
  endtask

  task automatic test_done_at_timeout();
    apply_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    cyc();
    repeat (16) cyc();
    core_done = 1'b1;
    #1;
    n_vec++; if (resp_valid_b !== 4'b0000 || busy_b !== 1'b1) begin n_err++; $display("FAIL tie_pre got resp=%b busy=%b want 0000 1", resp_valid_b, busy_b); end
    cyc();
    n_vec++; if (resp_valid_b !== 4'b0001 || resp_err_b !== 1'b0) begin n_err++; $display("FAIL tie_resp got=%b err=%b want=0001 err=0", resp_valid_b, resp_err_b); end
    core_done = 1'b0;
    cyc();
    $display("done at timeout: completion wins");
  endtask

  task automatic test_reset_mid_job();
    apply_reset();
    req_valid = 4'b1000;
    cyc();
    req_valid = 4'b0000;
    cyc(); cyc();
    n_vec++; if (busy_a !== 1'b1 || owner_a !== 3'd3) begin n_err++; $display("FAIL midreset_busy got busy=%b owner=%0d want 1 3", busy_a, owner_a); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    n_vec++; if (busy_a !== 1'b0 || resp_valid_a !== 4'b0000) begin n_err++; $display("FAIL midreset_idle got busy=%b resp=%b want 0 0000", busy_a, resp_valid_a); end
    req_valid = 4'b1010;
    #1;
    n_vec++; if (req_ready_a !== 4'b0010) begin n_err++; $display("FAIL midreset_regrant got=%b want=0010", req_ready_a); end
    req_valid = 4'b0000;
    cyc();
    $display("reset mid job: aborted, next grant to requester 1");
  endtask

  task automatic test_field_stability();
    apply_reset();
    set_fields(2, 2'b11, 32'hCAFE_0000, 32'h0000_0100, 32'hBEEF_0000);
    req_valid = 4'b0100;
    cyc();
    for (int i = 0; i < 4; i++) set_fields(i, 2'b00, 32'hDEAD_0000 + 32'(i), 32'h7, 32'hF00D_0000);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++; if (core_opcode_a !== 2'b11 || core_message_addr_a !== 32'hCAFE_0000 || core_size_a !== 32'h100 || core_output_addr_a !== 32'hBEEF_0000)
        begin n_err++; $display("FAIL stable_fields%0d got op=%b msg=%h size=%h out=%h", k, core_opcode_a, core_message_addr_a, core_size_a, core_output_addr_a); end
      n_vec++; if (req_ready_a !== 4'b0000) begin n_err++; $display("FAIL stable_no_ready%0d got=%b want=0000", k, req_ready_a); end
    end
    core_done = 1'b1;
    cyc();
    n_vec++; if (resp_valid_a !== 4'b0100 || core_size_a !== 32'h100) begin n_err++; $display("FAIL stable_resp got resp=%b size=%h want 0100 100", resp_valid_a, core_size_a); end
    core_done = 1'b0;
    cyc();
    n_vec++; if (req_ready_a !== 4'b1000) begin n_err++; $display("FAIL stable_next_grant got=%b want=1000", req_ready_a); end
    req_valid = 4'b0000;
    $display("field stability: requester 2 fields held through job");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_stale_done();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_job();
    test_field_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
